// File: rtl/branch_unit_if.sv
// Execute-stage branch unit bus: issue-side operands with valid/ready and the
// registered result with valid/ready toward writeback.
interface branch_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_ctrl;
  logic [2:0]      in_func3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_branch_type;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;

  modport master (
    output in_valid, in_ctrl, in_func3, in_pc, in_rs1, in_rs2, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_branch_type, out_taken, out_target,
           out_link, out_mispredict, out_redirect_pc
  );

  modport slave (
    input  in_valid, in_ctrl, in_func3, in_pc, in_rs1, in_rs2, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_branch_type, out_taken, out_target,
           out_link, out_mispredict, out_redirect_pc
  );
endinterface

// File: rtl/branch_unit.sv
// Registered branch resolution unit with misprediction detection.
// Optional 2-bit branch history table enabled by defining BRU_BHT_EN.
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  branch_unit_if.slave    bus,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken
);
  localparam logic [3:0] CTRL_JALR  = 4'b0010;
  localparam logic [3:0] CTRL_BTYPE = 4'b0001;

  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic signed [XLEN-1:0] a,
                                       input logic signed [XLEN-1:0] b);
    case (f3)
      3'b000:  branch_cond = (a == b);
      3'b001:  branch_cond = (a != b);
      3'b100:  branch_cond = (a < b);
      3'b101:  branch_cond = (a >= b);
      3'b110:  branch_cond = ($unsigned(a) < $unsigned(b));
      3'b111:  branch_cond = ($unsigned(a) >= $unsigned(b));
      default: branch_cond = 1'b0;
    endcase
  endfunction

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   one_hot;
  logic                   cond;
  logic                   taken;
  logic [3:0]             br_type;
  logic [XLEN-1:0]        target;
  logic [XLEN-1:0]        link;
  logic                   mispredict;
  logic [XLEN-1:0]        redirect;
  logic                   accept;
  logic                   drain;

  logic                   vld_p0;
  logic [3:0]             br_type_p0;
  logic                   taken_p0;
  logic [XLEN-1:0]        target_p0;
  logic [XLEN-1:0]        link_p0;
  logic                   mispredict_p0;
  logic [XLEN-1:0]        redirect_p0;

  logic unused_pred;
  assign unused_pred = ^pred_pc;

  assign rs1_s   = bus.in_rs1;
  assign rs2_s   = bus.in_rs2;
  assign one_hot = (bus.in_ctrl != 4'd0) &&
                   ((bus.in_ctrl & (bus.in_ctrl - 4'd1)) == 4'd0);

  always_comb begin
    cond    = branch_cond(bus.in_func3, rs1_s, rs2_s);
    link    = bus.in_pc + XLEN'(4);
    target  = bus.in_pc + bus.in_imm;
    if (bus.in_ctrl == CTRL_JALR)
      target = (bus.in_rs1 + bus.in_imm) & ~XLEN'(1);
    br_type = 4'b0000;
    taken   = 1'b0;
    // Malformed control vectors resolve to a plain not-taken, untyped op.
    if (one_hot) begin
      br_type = {bus.in_ctrl[3], bus.in_ctrl[2], bus.in_ctrl[1], bus.in_ctrl[0] & cond};
      taken   = bus.in_ctrl[2] | bus.in_ctrl[1] | (bus.in_ctrl[0] & cond);
    end
    mispredict = (taken != bus.in_pred_taken) ||
                 (taken && (target != bus.in_pred_target));
    redirect   = taken ? target : link;
  end

  assign bus.in_ready = ~vld_p0 | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~flush;
  assign drain        = vld_p0 & bus.out_ready;

  // Stage p0: one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0        <= 1'b0;
      br_type_p0    <= '0;
      taken_p0      <= 1'b0;
      target_p0     <= '0;
      link_p0       <= '0;
      mispredict_p0 <= 1'b0;
      redirect_p0   <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0        <= 1'b1;
      br_type_p0    <= br_type;
      taken_p0      <= taken;
      target_p0     <= target;
      link_p0       <= link;
      mispredict_p0 <= mispredict;
      redirect_p0   <= redirect;
    end else if (drain) begin
      vld_p0 <= 1'b0;
    end
  end

  assign bus.out_valid       = vld_p0;
  assign bus.out_branch_type = br_type_p0;
  assign bus.out_taken       = taken_p0;
  assign bus.out_target      = target_p0;
  assign bus.out_link        = link_p0;
  assign bus.out_mispredict  = mispredict_p0;
  assign bus.out_redirect_pc = redirect_p0;

`ifdef BRU_BHT_EN
  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) sat_step = (c == 2'b11) ? c : c + 2'b01;
    else    sat_step = (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [1:0]       bht [BHT_DEPTH];
  logic             btype_p0;
  logic [IDX_W-1:0] idx_p0;

  // Training happens when a branch leaves the output register, so flushed
  // entries never touch the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      btype_p0 <= 1'b0;
      idx_p0   <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else begin
      if (accept) begin
        btype_p0 <= (bus.in_ctrl == CTRL_BTYPE);
        idx_p0   <= bus.in_pc[IDX_W+1:2];
      end
      if (drain && !flush && btype_p0)
        bht[idx_p0] <= sat_step(bht[idx_p0], taken_p0);
    end
  end

  assign pred_taken = bht[pred_pc[IDX_W+1:2]][1];
`else
  localparam int unused_bht_depth = BHT_DEPTH;
  assign pred_taken = 1'b0;
`endif
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed cases plus randomized traffic
// compared every cycle against a behavioural model of the result slot and BHT.
module tb_branch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
`ifdef BRU_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pred_pc;
  logic        pred_taken;

  always #5 clk = ~clk;

  branch_unit_if #(.XLEN(XLEN)) bus ();

  branch_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken)
  );

  typedef struct packed {
    logic [3:0]  bt;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] lnk;
    logic        mp;
    logic [31:0] rd;
    logic        isb;
    logic [31:0] pc;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t held;
  bit   exp_valid = 1'b0;
  bit   data_chk  = 1'b0;
  bit   model_on  = 1'b0;
  int   cnt [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a branch unit must produce for one operation.
  function automatic res_t model(input logic [3:0] ctrl, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm,
                                 input logic pt, input logic [31:0] ptgt);
    res_t r;
    logic c;
    case (f3)
      3'd0:    c = (rs1 == rs2);
      3'd1:    c = (rs1 != rs2);
      3'd4:    c = ($signed(rs1) < $signed(rs2));
      3'd5:    c = ($signed(rs1) >= $signed(rs2));
      3'd6:    c = (rs1 < rs2);
      3'd7:    c = (rs1 >= rs2);
      default: c = 1'b0;
    endcase
    r     = '0;
    r.pc  = pc;
    r.lnk = pc + 32'd4;
    r.tgt = (ctrl == 4'b0010) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    case (ctrl)
      4'b1000: begin r.tk = 1'b0; r.bt = 4'b1000; end
      4'b0100: begin r.tk = 1'b1; r.bt = 4'b0100; end
      4'b0010: begin r.tk = 1'b1; r.bt = 4'b0010; end
      4'b0001: begin r.tk = c;    r.bt = {3'b000, c}; r.isb = 1'b1; end
      default: begin r.tk = 1'b0; r.bt = 4'b0000; end
    endcase
    r.mp = (r.tk != pt) || (r.tk && (r.tgt != ptgt));
    r.rd = r.tk ? r.tgt : r.lnk;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_valid = 1'b0;
      held      = '0;
      data_chk  = 1'b1;
      model_on  = 1'b1;
      for (int i = 0; i < DEPTH; i++) cnt[i] = 1;
    end else if (model_on) begin
      if (!flush && exp_valid && bus.out_ready && held.isb) begin
        int k;
        k = int'((held.pc >> 2) % DEPTH);
        cnt[k] = held.tk ? ((cnt[k] < 3) ? cnt[k] + 1 : 3) : ((cnt[k] > 0) ? cnt[k] - 1 : 0);
      end
      if (flush) begin
        exp_valid = 1'b0;
        data_chk  = 1'b0;
      end else if (bus.in_valid && (!exp_valid || bus.out_ready)) begin
        held = model(bus.in_ctrl, bus.in_func3, bus.in_pc, bus.in_rs1, bus.in_rs2,
                     bus.in_imm, bus.in_pred_taken, bus.in_pred_target);
        exp_valid = 1'b1;
        data_chk  = 1'b1;
      end else if (exp_valid && bus.out_ready) begin
        exp_valid = 1'b0;
        data_chk  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic exp_pt;
      #2;
      exp_pt = BHT_ON ? (cnt[int'((pred_pc >> 2) % DEPTH)] >= 2) : 1'b0;
      chk("out_valid", bus.out_valid, exp_valid);
      chk("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
      chk("pred_taken", pred_taken, exp_pt);
      if (data_chk) begin
        chk("branch_type", bus.out_branch_type, held.bt);
        chk("taken", bus.out_taken, held.tk);
        chk("target", bus.out_target, held.tgt);
        chk("link", bus.out_link, held.lnk);
        chk("mispredict", bus.out_mispredict, held.mp);
        chk("redirect_pc", bus.out_redirect_pc, held.rd);
      end
    end
  end

  task automatic set_op(input logic [3:0] ctrl, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt);
    bus.in_ctrl        = ctrl;
    bus.in_func3       = f3;
    bus.in_pc          = pc;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_imm         = imm;
    bus.in_pred_taken  = pt;
    bus.in_pred_target = ptgt;
  endtask

  // Called just after a falling edge; returns with the op in the output register.
  task automatic send(input logic [3:0] ctrl, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                      input logic pt, input logic [31:0] ptgt);
    set_op(ctrl, f3, pc, rs1, rs2, imm, pt, ptgt);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
  endtask

  task automatic idle();
    @(negedge clk);
    #3;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    pred_pc       = 32'h40;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(4'b0000, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_target", bus.out_target, 32'h0);
    chk("rst_pred_taken", pred_taken, 1'b0);

    send(4'b0001, 3'd6, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
    chk("bltu_taken", bus.out_taken, 1'b0);
    chk("bltu_mispredict", bus.out_mispredict, 1'b0);
    chk("bltu_redirect", bus.out_redirect_pc, 32'h104);
    send(4'b0001, 3'd4, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
    chk("blt_taken", bus.out_taken, 1'b1);
    chk("blt_target", bus.out_target, 32'h120);
    chk("blt_mispredict", bus.out_mispredict, 1'b1);
    send(4'b0010, 3'd0, 32'h200, 32'h1003, 32'h0, 32'h10, 1'b1, 32'h1012);
    chk("jalr_target", bus.out_target, 32'h1012);
    chk("jalr_link", bus.out_link, 32'h204);
    chk("jalr_mispredict", bus.out_mispredict, 1'b0);
    send(4'b0010, 3'd0, 32'h200, 32'h1003, 32'h0, 32'h10, 1'b1, 32'h1013);
    chk("jalr_bad_target", bus.out_mispredict, 1'b1);
    send(4'b0100, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b1, 32'h4);
    chk("jal_wrap_target", bus.out_target, 32'h4);
    chk("jal_wrap_link", bus.out_link, 32'h0);
    send(4'b0011, 3'd0, 32'h10, 32'h0, 32'h0, 32'h8, 1'b0, 32'h0);
    chk("nonhot_type", bus.out_branch_type, 4'b0000);
    chk("nonhot_taken", bus.out_taken, 1'b0);

    // History training at pc 0x40
    send(4'b0001, 3'd0, 32'h40, 32'h5, 32'h5, 32'h40, 1'b0, 32'h0);
    idle();
    chk("bht_first_update", pred_taken, BHT_ON);
    send(4'b0001, 3'd0, 32'h40, 32'h5, 32'h5, 32'h40, 1'b1, 32'h80);
    send(4'b0001, 3'd0, 32'h40, 32'h5, 32'h5, 32'h40, 1'b1, 32'h80);
    idle();
    chk("bht_saturated", pred_taken, BHT_ON);
    send(4'b0001, 3'd0, 32'h40, 32'h5, 32'h6, 32'h40, 1'b1, 32'h80);
    idle();
    chk("bht_down_one", pred_taken, BHT_ON);
    send(4'b0001, 3'd0, 32'h40, 32'h5, 32'h6, 32'h40, 1'b1, 32'h80);
    idle();
    chk("bht_down_two", pred_taken, 1'b0);

    // Flush a held taken branch while a new op is offered
    bus.out_ready = 1'b0;
    send(4'b0001, 3'd0, 32'h40, 32'h7, 32'h7, 32'h40, 1'b0, 32'h0);
    chk("flush_held", bus.out_valid, 1'b1);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    set_op(4'b0100, 3'd0, 32'h600, 32'h0, 32'h0, 32'h4, 1'b1, 32'h604);
    bus.in_valid  = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_no_train", pred_taken, 1'b0);
    idle();
    chk("flush_dropped", bus.out_valid, 1'b0);

    // Backpressure then release
    bus.out_ready = 1'b0;
    set_op(4'b0100, 3'd0, 32'h300, 32'h0, 32'h0, 32'h10, 1'b1, 32'h310);
    bus.in_valid = 1'b1;
    @(negedge clk);
    set_op(4'b0100, 3'd0, 32'h400, 32'h0, 32'h0, 32'h20, 1'b1, 32'h420);
    repeat (3) begin
      #3;
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_hold", bus.out_target, 32'h310);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("bp_second", bus.out_target, 32'h420);
    set_op(4'b1000, 3'd0, 32'h500, 32'h0, 32'h0, 32'h1000, 1'b0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    chk("bp_third", bus.out_target, 32'h1500);
    idle();

    // Randomized traffic
    repeat (3000) begin
      int r;
      logic [31:0] rs1, pc, imm;
      @(negedge clk);
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      bus.in_ctrl = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom());
      if (r < 8 && $urandom_range(0, 1) == 1) bus.in_ctrl = 4'b0001;
      bus.in_func3 = 3'($urandom());
      rs1 = $urandom();
      bus.in_rs1 = rs1;
      bus.in_rs2 = ($urandom_range(0, 9) < 3) ? rs1 : $urandom();
      pc  = ($urandom_range(0, 4) == 0) ? $urandom() : (32'h40 + 32'($urandom_range(0, 7)) * 4);
      imm = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 63)) * 4;
      bus.in_pc  = pc;
      bus.in_imm = imm;
      bus.in_pred_taken  = 1'($urandom());
      bus.in_pred_target = ($urandom_range(0, 1) == 0) ? (pc + imm) : $urandom();
      pred_pc = 32'h40 + 32'($urandom_range(0, 7)) * 4;
    end
    @(negedge clk);
    rst          = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised, registered branch resolution unit for the execute stage. It resolves conditional branches, jal and jalr from a one-hot control vector, computes target and link addresses, and compares the outcome with the fetch-stage prediction. It flags mispredictions with the correct redirect PC. A valid/ready handshake and a one-entry output register decouple it from writeback. An optional 2-bit branch history table gives fetch a taken/not-taken prediction.

## Interface
Parameters:
- XLEN, 32, datapath/address width (≥ 8)
- BHT_DEPTH, 64, history table entries (power of two ≥ 2; used only with BRU_BHT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held and incoming operation
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_ctrl  in  4  one-hot {auipc, jal, jalr, btype}
- in_func3  in  3  branch condition (RV32I encoding)
- in_pc, in_rs1, in_rs2, in_imm  in  XLEN  operands
- in_pred_taken  in  1  fetch predicted taken
- in_pred_target  in  XLEN  fetch predicted target
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_branch_type  out  4  {auipc, jal, jalr, btype_taken}
- out_taken  out  1  control transfer taken
- out_target  out  XLEN  resolved target (auipc: pc+imm)
- out_link  out  XLEN  pc+4
- out_mispredict  out  1  redirect required
- out_redirect_pc  out  XLEN  correct next PC
- pred_pc  in  XLEN  fetch lookup PC
- pred_taken  out  1  fetch prediction (combinational)

## Operation
- Condition: beq eq, bne ne, blt signed lt, bge signed ge, bltu unsigned lt, bgeu unsigned ge. func3 010/011 never taken.
- btype: taken = condition; target = pc+imm.
- jal: taken = 1; target = pc+imm.
- jalr: taken = 1; target = (rs1+imm) with bit 0 cleared.
- auipc: taken = 0; target = pc+imm (result value, not a redirect).
- in_ctrl = 0 or non-one-hot: all of taken and branch_type are 0.
- Arithmetic is XLEN-bit and wraps modulo 2^XLEN.
- mispredict = (taken != pred_taken) | (taken & target != pred_target).
- redirect_pc = taken ? target : pc+4.
- All results are computed combinationally from inputs and captured into the output register on accept.

## Timing
- Reset values: out_valid 0, every other out_* 0. BHT counters = 2'b01 (weakly not-taken).
- in_ready = ~out_valid | out_ready. This provides full throughput of one operation per cycle.
- Latency: accepted at edge N → out_valid high after edge N, held stable until out_valid & out_ready.
- Simultaneous drain and accept: new result is loaded and out_valid stays 1.
- flush: out_valid is 0 after the edge. An input offered in the same cycle is dropped. flush has priority over accept. No BHT update occurs for flushed entries.
- Data outputs are don't-care while out_valid = 0, except at reset.
- Reset mid-operation: held entry discarded, table reinitialised, same as the reset state.

## Configuration
- BRU_BHT_EN defined:
  - BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
  - pred_taken = counter[pred_pc index][1].
  - Update on output handshake of btype entries only: increment if taken, decrement otherwise, saturating at 3 and 0.
  - A lookup of the index being updated in the same cycle returns the old value.
  - Reset reinitialises all counters in one cycle.
- BRU_BHT_EN undefined: no table storage; pred_taken = 0 (static not-taken). BHT_DEPTH is ignored.

## Test plan
- Reset, then bltu with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 → next cycle out_taken=0, out_mispredict=0, out_redirect_pc=0x104. Same operands with blt → taken, target 0x120, mispredict=1.
- jalr rs1=0x1003, imm=0x10, pred_taken=1, pred_target=0x1012 → target 0x1012, link pc+4, mispredict=0. Same with pred_target=0x1013 → mispredict=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, output stable. Release → back-to-back results one per cycle with no loss.
- flush asserted with out_valid=1 and a new in_valid=1 → out_valid=0 next cycle, neither operation appears, BHT unchanged.
- With BRU_BHT_EN defined: three taken beq at pc=0x40 → pred_taken for pred_pc=0x40 goes 0→1 after the first update, saturates at 3. Two not-taken → counter 1, pred_taken=0. With the macro undefined → pred_taken is always 0.
- pc=0xFFFFFFFC, jal imm=8 → target 0x4 and link 0x0 (wrap-around).
